// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its decoder.
package fetch_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF      = 32'h0000_0000;
  localparam logic [5:0]  BUBBLE_OPCODE_DEF = 6'b111111;

  localparam logic [5:0] R_FMT = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register: synchronous reset to RESET_PC, loads next_i when load_i.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] next_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset)       pc_q <= RESET_PC;
    else if (load_i) pc_q <= next_i;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: request at pc, hold the returned word
// until decode accepts it, and steer to branch targets that arrive at any time.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter logic [5:0]  BUBBLE_OPCODE = BUBBLE_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc, pc_next;
  logic         pc_load;
  logic [31:0]  instr_q, instr_d, pc_out_q, pc_out_d, redir_pc_q, redir_pc_d;
  logic         valid_q, valid_d, redir_pend_q, redir_pend_d;
  logic         post_rst_q, ack_eff;
  logic [31:0]  br_tgt;

  // The first cycle out of reset may see the ack of an abandoned access.
  assign ack_eff = imem_ack & ~post_rst_q;
  assign br_tgt  = align_word(branch_target);

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load_i (pc_load),
    .next_i (pc_next),
    .pc_o   (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (ack_eff && !redir_pend_q && !branch_taken) state_d = S_HOLD;
      S_HOLD:  if (branch_taken || !stall)                    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = ~reset && (state_q == S_FETCH);
    opcode   = valid_q ? instr_q[31:26] : BUBBLE_OPCODE;
  end

  always_comb begin
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    pc_load      = 1'b0;
    pc_next      = pc_plus4;
    case (state_q)
      S_FETCH: begin
        if (ack_eff) begin
          if (redir_pend_q || branch_taken) begin
            pc_load      = 1'b1;
            pc_next      = branch_taken ? br_tgt : redir_pc_q;
            redir_pend_d = 1'b0;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc;
            valid_d  = 1'b1;
          end
        end else if (branch_taken) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = br_tgt;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          pc_next = br_tgt;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    post_rst_q <= reset;
    if (reset) begin
      instr_q      <= '0;
      pc_out_q     <= RESET_PC;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;
  assign instr_valid = valid_q;

endmodule
